// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential 32-bit ALU with a bit-serial right shifter.
//
// Add/sub/and/or and the reserved ops resolve on the accept edge and go
// straight to DONE. Shifts by a non-zero amount walk through SHIFT one bit
// per cycle, so an n-bit shift takes n+1 cycles from accept to out_valid.
// One request is in flight at a time; the request/response handshake is
// decoded purely from the FSM state.
//
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the 'zero' output
// (C == 0, valid in every state). Without it the port and logic are absent.
//
// Ports
//   clk        system clock, rising-edge
//   reset      asynchronous active-high reset
//   in_valid   request present on A/B/ALUOp
//   in_ready   block can take a request (IDLE only)
//   A, B       operands; B[4:0] is the shift amount for ops 4/5
//   ALUOp      0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, 6/7 reserved (C=0)
//   out_valid  C holds a result (DONE only)
//   out_ready  consumer takes C this cycle
//   C          result
//   busy       state != IDLE
//   zero       C == 0 (ALU_SEQ_ZERO_FLAG_EN only)
// ---------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUOp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] C,
    output logic        busy
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,output logic        zero
`endif
);

    localparam int W = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    // res_q is both the shift work register and the result register: while
    // in SHIFT it holds the partially shifted operand, in DONE the answer.
    logic [W-1:0] res_q;
    logic [4:0]   cnt_q;
    logic         sra_q;    // latched: fill vacated MSB with the sign bit

    logic         accept;
    logic         is_shift;
    logic [4:0]   shamt;
    logic [W-1:0] alu_res;

    assign accept   = in_valid && (state_q == IDLE);
    assign is_shift = (ALUOp == OP_SRL) || (ALUOp == OP_SRA);
    assign shamt    = B[4:0];

    // Single-cycle result; for shifts this is the starting work value,
    // which is also the final answer when the shift amount is zero.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            OP_ADD:         alu_res = A + B;
            OP_SUB:         alu_res = A - B;
            OP_AND:         alu_res = A & B;
            OP_OR:          alu_res = A | B;
            OP_SRL, OP_SRA: alu_res = A;
            default:        alu_res = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != 5'd0)) state_nxt = SHIFT;
                    else                             state_nxt = DONE;
                end
            end
            // Leave on the edge that performs the last shift (counter 1->0).
            SHIFT: if (cnt_q == 5'd1) state_nxt = DONE;
            DONE:  if (out_ready)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            cnt_q <= '0;
            sra_q <= 1'b0;
        end else if (accept) begin
            res_q <= alu_res;
            if (is_shift) begin
                cnt_q <= shamt;
                sra_q <= (ALUOp == OP_SRA);
            end
        end else if (state_q == SHIFT) begin
            res_q <= {sra_q & res_q[W-1], res_q[W-1:1]};
            cnt_q <= cnt_q - 5'd1;
        end
    end

    // ---------------- outputs ----------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign C         = res_q;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign zero = (res_q == '0);
`endif

`ifndef SYNTHESIS
    // SHIFT is only entered with a non-zero count.
    a_shift_cnt: assert property (@(posedge clk) disable iff (reset)
        (state_q == SHIFT) |-> (cnt_q != 5'd0));
    // A stalled result must not move.
    a_done_hold: assert property (@(posedge clk) disable iff (reset)
        (state_q == DONE && !out_ready) |=> (state_q == DONE && $stable(res_q)));
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        clk, reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] A, B, C;
    logic [2:0]  ALUOp;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        zero;
`endif

    alu_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid),
        .out_ready(out_ready), .C(C), .busy(busy)
`ifdef ALU_SEQ_ZERO_FLAG_EN
       ,.zero(zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the op definitions.
    function automatic logic [31:0] model_c(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> b[4:0];
            3'd5: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] b, input logic [2:0] op);
        if (op == 3'd4 || op == 3'd5) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Call between a negedge and the next posedge; returns just after a negedge.
    // Inputs are scrambled and in_valid held high after the accept edge to
    // show the operands are latched and extra requests are ignored.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] exp_c, input int exp_lat, input int hold,
                          input string nm);
        int lat;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; ALUOp = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        A = $urandom; B = $urandom; ALUOp = 3'($urandom);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " C"}, C, exp_c);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk({nm, " zero"}, 32'(zero), 32'(exp_c == 32'h0));
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, " hold C"}, C, exp_c);
            chk({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk({nm, " release out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " release in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " release busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " C"}, C, 32'h0);
        chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk({nm, " zero"}, 32'(zero), 32'd1);
`endif
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] c;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'hffff0000, 32'd3,          3'd5, 32'hffffe000, 4,  5};
        vecs[1]  = '{32'hffff0000, 32'd3,          3'd4, 32'h1fffe000, 4,  0};
        vecs[2]  = '{32'hffffffff, 32'd1,          3'd0, 32'h00000000, 1,  0};
        vecs[3]  = '{32'h00000005, 32'd7,          3'd1, 32'hfffffffe, 1,  2};
        vecs[4]  = '{32'h80000000, 32'd31,         3'd5, 32'hffffffff, 32, 0};
        vecs[5]  = '{32'h80000000, 32'd32,         3'd5, 32'h80000000, 1,  0};
        vecs[6]  = '{32'h00000003, 32'd4,          3'd3, 32'h00000007, 1,  0};
        vecs[7]  = '{32'hf0f0f0f0, 32'hff00ff00,   3'd2, 32'hf000f000, 1,  1};
        vecs[8]  = '{32'h12345678, 32'd0,          3'd6, 32'h00000000, 1,  0};
        vecs[9]  = '{32'hdeadbeef, 32'd1,          3'd7, 32'h00000000, 1,  0};
        vecs[10] = '{32'h80000000, 32'd31,         3'd4, 32'h00000001, 32, 0};
        vecs[11] = '{32'h7fffffff, 32'd1,          3'd0, 32'h80000000, 1,  0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALUOp = '0;
        #1;
        chk_reset_vals("por");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Directed table; first op accepted on the first edge after reset release.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].lat,
                   vecs[i].hold, $sformatf("vec%0d", i));

        // Reset in the middle of a 20-bit shift.
        A = 32'h80000000; B = 32'd20; ALUOp = 3'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_shift busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_shift");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        run_op(32'd3, 32'd4, 3'd3, 32'd7, 1, 0, "post_rst");

        // Reset while a result waits in DONE.
        A = 32'd10; B = 32'd20; ALUOp = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_pre out_valid", 32'(out_valid), 32'd1);
        chk("done_pre C", C, 32'd30);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_done");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done stale out_valid", 32'(out_valid), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            logic [2:0]  rop;
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            if (i % 5 == 0) ra = 32'h0;
            run_op(ra, rb, rop, model_c(ra, rb, rop), model_lat(rb, rop),
                   int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
